dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single-port data memory (combinational read, write on posedge clk) between the CPU load/store stage and a DMA/loader port.
- Performs one memory access per cycle and drives the memory's address, mem_write, mem_read and write_data.
- Returns registered read data with a valid strobe.
- Bounds bursts so neither requester starves.

Parameters:
- DATA_W, 32, data width.
- ADDR_W, 32, address width.
- MAX_BURST, 4, maximum consecutive grants to one owner while the other requester waits (legal range 1..15).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- cpu_req  in  1  CPU request; held with cpu_we/cpu_addr/cpu_wdata stable until cpu_gnt.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  access performed this cycle.
- cpu_rvalid  out  1  cpu_rdata valid (one cycle after a granted read).
- cpu_rdata  out  DATA_W  registered read data.
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata: identical meaning and widths for the DMA port.
- mem_address  out  ADDR_W  to memory address.
- mem_write  out  1  to memory mem_write.
- mem_read  out  1  to memory mem_read.
- mem_write_data  out  DATA_W  to memory write_data.
- mem_read_data  in  DATA_W  from memory read_data.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- FSM states: IDLE, OWN_CPU, OWN_DMA. Registers: burst_cnt (4 bits) and last_owner.
- Reset values: state=IDLE, burst_cnt=0, last_owner=DMA (so the CPU wins the first tie), both rvalid=0, both rdata=0.
- Memory gating: while rst_n=0, mem_write=0 and mem_read=0 combinationally, so no write occurs on a reset edge.
- Grant logic (combinational): cpu_gnt = (state==OWN_CPU) & cpu_req. dma_gnt likewise.
- Memory drive: mem_* are muxed from the owner's inputs. mem_write = gnt & we; mem_read = gnt & ~we. With no grant, mem_address=0 and mem_write=mem_read=0.
- Latency: request seen in cycle N from IDLE → grant in cycle N+1. Read data is captured into rdata at the end of the grant cycle, so rvalid=1 in cycle N+2 for exactly one cycle. Writes commit at the end of the grant cycle.
- From IDLE: only one req → that owner. Both → tie rule (Optional Feature). None → stay IDLE.
- In OWN_X with X granted this cycle, other requester idle → stay OWN_X; burst_cnt saturates at MAX_BURST.
- In OWN_X with X granted this cycle, other requesting:
  - burst_cnt+1 < MAX_BURST → stay OWN_X, burst_cnt++.
  - otherwise → switch directly to the other owner, burst_cnt=0, last_owner=X. No idle bubble.
- In OWN_X with X_req=0 (request dropped): no access this cycle. Next state is OWN_other if the other is requesting, else IDLE; burst_cnt=0.
- burst_cnt resets to 0 on every owner change and on entry to IDLE.
- rdata holds its value until the next granted read for that port.
- Reset mid-burst: the pending request is not granted. After release, arbitration restarts from IDLE.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: IDLE ties go to the requester that is not last_owner (round-robin).
- Undefined: IDLE ties always go to the CPU. last_owner is still maintained but unused.
- Burst limiting is identical in both builds.

Decomposition:
- Package dmem_arb_pkg: state enum (IDLE, OWN_CPU, OWN_DMA), owner encoding (OWNER_CPU=0, OWNER_DMA=1), burst counter width constant.
- One natural sub-module: dmem_arb_rport, instantiated twice. It holds the per-port read-return register: rdata/rvalid capture on a granted read, hold otherwise.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with both req=1 and we=1 → mem_write=0 every cycle, all gnt/rvalid=0, rdata=0.
- CPU write then read: write 0xDEADBEEF to addr 5, then read addr 5 → cpu_gnt in the cycle after req, cpu_rdata=0xDEADBEEF with cpu_rvalid=1 two cycles after the read req.
- Contention with MAX_BURST=4: both hold req continuously from IDLE → grant pattern CPU×4, DMA×4, CPU×4, with no idle cycle between owners.
- Tie-break: two back-to-back single-cycle simultaneous requests from IDLE → with DMEM_ARB_RR_EN, CPU then DMA; without it, CPU then CPU.
- Dropped request: CPU owns, deasserts cpu_req while DMA idle → one no-access cycle, then IDLE; a DMA req in a later cycle is granted on the next cycle.
- Reset mid-burst: rst_n low during 2nd CPU grant of a write burst → that write is not committed, state returns to IDLE, and arbitration restarts after release.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arb_pkg : shared types/constants for the data-memory arbiter    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_DMA = 2'd2
    } arb_state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    localparam int BURST_W = 4;

endpackage
`default_nettype wire

// File: rtl/dmem_arb_rport.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arb_rport : per-port read-return register (rdata + rvalid)      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dmem_arb_rport #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gnt,
    input  logic              we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    logic rd_hit;
    assign rd_hit = gnt & ~we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= rd_hit;
            if (rd_hit) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arbiter : CPU/DMA arbiter for a single-port data memory with    |
// | burst limiting. DMEM_ARB_RR_EN selects round-robin IDLE tie-break.    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write,
    output logic              mem_read,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [BURST_W:0] BURST_LIMIT = (BURST_W+1)'(MAX_BURST);

    arb_state_t         state, state_nxt;
    logic [BURST_W-1:0] burst_cnt, burst_cnt_nxt;
    logic               last_owner, last_owner_nxt;
    logic [BURST_W:0]   cnt_inc;
    logic               tie_to_cpu;

    assign cnt_inc = {1'b0, burst_cnt} + 1'b1;

`ifdef DMEM_ARB_RR_EN
    assign tie_to_cpu = (last_owner == OWNER_DMA);
`else
    // CPU always wins; last_owner is still tracked for the round-robin build
    assign tie_to_cpu = 1'b1 | (last_owner == OWNER_DMA);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            last_owner <= OWNER_DMA;
        end else begin
            state      <= state_nxt;
            burst_cnt  <= burst_cnt_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        burst_cnt_nxt  = burst_cnt;
        last_owner_nxt = last_owner;
        case (state)
            IDLE: begin
                burst_cnt_nxt = '0;
                if (cpu_req && (!dma_req || tie_to_cpu)) begin
                    state_nxt = OWN_CPU;
                end else if (dma_req) begin
                    state_nxt = OWN_DMA;
                end
            end
            OWN_CPU: begin
                if (cpu_req) begin
                    last_owner_nxt = OWNER_CPU;
                    if (dma_req) begin
                        if (cnt_inc < BURST_LIMIT) begin
                            burst_cnt_nxt = cnt_inc[BURST_W-1:0];
                        end else begin
                            state_nxt     = OWN_DMA;
                            burst_cnt_nxt = '0;
                        end
                    end else if (cnt_inc <= BURST_LIMIT) begin
                        burst_cnt_nxt = cnt_inc[BURST_W-1:0];
                    end
                end else begin
                    burst_cnt_nxt = '0;
                    state_nxt     = dma_req ? OWN_DMA : IDLE;
                end
            end
            OWN_DMA: begin
                if (dma_req) begin
                    last_owner_nxt = OWNER_DMA;
                    if (cpu_req) begin
                        if (cnt_inc < BURST_LIMIT) begin
                            burst_cnt_nxt = cnt_inc[BURST_W-1:0];
                        end else begin
                            state_nxt     = OWN_CPU;
                            burst_cnt_nxt = '0;
                        end
                    end else if (cnt_inc <= BURST_LIMIT) begin
                        burst_cnt_nxt = cnt_inc[BURST_W-1:0];
                    end
                end else begin
                    burst_cnt_nxt = '0;
                    state_nxt     = cpu_req ? OWN_CPU : IDLE;
                end
            end
            default: begin
                state_nxt     = IDLE;
                burst_cnt_nxt = '0;
            end
        endcase
    end

    // Grants are masked by rst_n so nothing reaches memory on a reset edge
    always_comb begin
        cpu_gnt        = rst_n & (state == OWN_CPU) & cpu_req;
        dma_gnt        = rst_n & (state == OWN_DMA) & dma_req;
        mem_address    = '0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        mem_write_data = '0;
        if (cpu_gnt) begin
            mem_address    = cpu_addr;
            mem_write      = cpu_we;
            mem_read       = ~cpu_we;
            mem_write_data = cpu_wdata;
        end else if (dma_gnt) begin
            mem_address    = dma_addr;
            mem_write      = dma_we;
            mem_read       = ~dma_we;
            mem_write_data = dma_wdata;
        end
    end

    dmem_arb_rport #(.DATA_W(DATA_W)) u_cpu_rport (
        .clk       (clk),
        .rst_n     (rst_n),
        .gnt       (cpu_gnt),
        .we        (cpu_we),
        .mem_rdata (mem_read_data),
        .rvalid    (cpu_rvalid),
        .rdata     (cpu_rdata)
    );

    dmem_arb_rport #(.DATA_W(DATA_W)) u_dma_rport (
        .clk       (clk),
        .rst_n     (rst_n),
        .gnt       (dma_gnt),
        .we        (dma_we),
        .mem_rdata (mem_read_data),
        .rvalid    (dma_rvalid),
        .rdata     (dma_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_arbiter : directed self-checking bench for dmem_arbiter      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [31:0] cpu_rdata, dma_rdata;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write, mem_read;
    logic        mem_clr;
    logic [31:0] mem [0:15];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_gnt        (cpu_gnt),
        .cpu_rvalid     (cpu_rvalid),
        .cpu_rdata      (cpu_rdata),
        .dma_req        (dma_req),
        .dma_we         (dma_we),
        .dma_addr       (dma_addr),
        .dma_wdata      (dma_wdata),
        .dma_gnt        (dma_gnt),
        .dma_rvalid     (dma_rvalid),
        .dma_rdata      (dma_rdata),
        .mem_address    (mem_address),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Behavioural single-port memory: combinational read, posedge write
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 16; k++) mem[k] <= 32'h0;
        end else if (mem_write) begin
            mem[mem_address[3:0]] <= mem_write_data;
        end
    end
    assign mem_read_data = mem[mem_address[3:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_cpu;
        rst_n     = 1'b0;
        mem_clr   = 1'b1;
        cpu_req   = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd3; cpu_wdata = 32'hAAAA_AAAA;
        dma_req   = 1'b1; dma_we = 1'b1; dma_addr = 32'd4; dma_wdata = 32'hBBBB_BBBB;

        // Reset held with both requesters writing
        for (int i = 0; i < 3; i++) begin
            tick();
            mem_clr = 1'b0;
            #1;
            chk1("rst_mem_write", mem_write, 1'b0);
            chk1("rst_mem_read", mem_read, 1'b0);
            chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
            chk1("rst_dma_gnt", dma_gnt, 1'b0);
            chk1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
            chk1("rst_dma_rvalid", dma_rvalid, 1'b0);
            chk32("rst_cpu_rdata", cpu_rdata, 32'h0);
            chk32("rst_dma_rdata", dma_rdata, 32'h0);
        end
        chk32("rst_no_write3", mem[3], 32'h0);
        chk32("rst_no_write4", mem[4], 32'h0);

        // CPU write 0xDEADBEEF to address 5
        rst_n = 1'b1; dma_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd5; cpu_wdata = 32'hDEAD_BEEF;
        #1;
        chk1("wr_idle_nognt", cpu_gnt, 1'b0);
        tick();
        chk1("wr_gnt", cpu_gnt, 1'b1);
        chk1("wr_mem_write", mem_write, 1'b1);
        chk32("wr_addr", mem_address, 32'd5);
        chk32("wr_data", mem_write_data, 32'hDEAD_BEEF);
        tick();
        cpu_req = 1'b0; #1;
        chk1("wr_drop_nognt", cpu_gnt, 1'b0);
        chk1("wr_drop_nowrite", mem_write, 1'b0);
        chk32("wr_committed", mem[5], 32'hDEAD_BEEF);

        // CPU read back address 5
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; #1;
        chk1("rd_idle_nognt", cpu_gnt, 1'b0);
        tick();
        chk1("rd_gnt", cpu_gnt, 1'b1);
        chk1("rd_mem_read", mem_read, 1'b1);
        chk1("rd_rvalid_early", cpu_rvalid, 1'b0);
        tick();
        cpu_req = 1'b0; #1;
        chk1("rd_rvalid", cpu_rvalid, 1'b1);
        chk32("rd_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk1("drop_no_access", mem_read, 1'b0);

        // Back in IDLE after the dropped request; DMA read granted next cycle
        tick();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'd5; #1;
        chk1("rd_rvalid_pulse", cpu_rvalid, 1'b0);
        chk32("rd_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);
        chk1("dma_idle_nognt", dma_gnt, 1'b0);
        tick();
        chk1("dma_gnt", dma_gnt, 1'b1);
        chk1("dma_cpu_nognt", cpu_gnt, 1'b0);
        chk32("dma_addr", mem_address, 32'd5);
        tick();
        dma_req = 1'b0; #1;
        chk1("dma_rvalid", dma_rvalid, 1'b1);
        chk32("dma_rdata", dma_rdata, 32'hDEAD_BEEF);
        tick();

        // First IDLE tie: last owner was DMA, so CPU wins in both builds
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd5;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'd5; #1;
        chk1("tie1_idle_cpu", cpu_gnt, 1'b0);
        chk1("tie1_idle_dma", dma_gnt, 1'b0);
        tick();
        dma_req = 1'b0; #1;
        chk1("tie1_cpu_gnt", cpu_gnt, 1'b1);
        chk1("tie1_dma_gnt", dma_gnt, 1'b0);
        tick();
        cpu_req = 1'b0; #1;
        chk1("tie1_gap", cpu_gnt | dma_gnt, 1'b0);
        tick();
        cpu_req = 1'b1; dma_req = 1'b1;
        tick();
`ifdef DMEM_ARB_RR_EN
        chk1("tie2_cpu_gnt", cpu_gnt, 1'b0);
        chk1("tie2_dma_gnt", dma_gnt, 1'b1);
`else
        chk1("tie2_cpu_gnt", cpu_gnt, 1'b1);
        chk1("tie2_dma_gnt", dma_gnt, 1'b0);
`endif
        tick();
        cpu_req = 1'b0; dma_req = 1'b0; #1;
        chk1("tie2_release", cpu_gnt | dma_gnt, 1'b0);
        tick();

        // Continuous contention: CPUx4, DMAx4, CPUx4 with no bubble
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd1; cpu_wdata = 32'h1111_0001;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'd2; dma_wdata = 32'h2222_0002;
        #1;
        chk1("burst_idle", cpu_gnt | dma_gnt, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_cpu = (i < 4) || (i >= 8);
            chk1("burst_cpu_gnt", cpu_gnt, exp_cpu);
            chk1("burst_dma_gnt", dma_gnt, ~exp_cpu);
            chk32("burst_addr", mem_address, exp_cpu ? 32'd1 : 32'd2);
        end
        tick();
        cpu_req = 1'b0; dma_req = 1'b0; #1;
        chk1("burst_end", cpu_gnt | dma_gnt, 1'b0);
        chk32("burst_mem1", mem[1], 32'h1111_0001);
        chk32("burst_mem2", mem[2], 32'h2222_0002);
        tick();

        // Reset asserted during the second grant of a CPU write burst
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd7; cpu_wdata = 32'h7777_7777;
        tick();
        chk1("mid_gnt1", cpu_gnt, 1'b1);
        chk1("mid_write1", mem_write, 1'b1);
        tick();
        cpu_addr = 32'd8; cpu_wdata = 32'h8888_8888; rst_n = 1'b0; #1;
        chk1("mid_rst_gnt", cpu_gnt, 1'b0);
        chk1("mid_rst_write", mem_write, 1'b0);
        tick();
        rst_n = 1'b1; #1;
        chk1("mid_restart_idle", cpu_gnt, 1'b0);
        chk32("mid_mem7", mem[7], 32'h7777_7777);
        chk32("mid_mem8_blocked", mem[8], 32'h0);
        tick();
        chk1("mid_regrant", cpu_gnt, 1'b1);
        chk32("mid_regrant_addr", mem_address, 32'd8);
        tick();
        cpu_req = 1'b0; #1;
        chk32("mid_mem8_written", mem[8], 32'h8888_8888);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
